// File: rtl/cmd_issue_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the command issue controller: register map, STATUS bits, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cmd_issue_pkg;

  // Register map
  localparam logic [2:0] ADDR_ARG      = 3'd0;
  localparam logic [2:0] ADDR_CMD      = 3'd1;
  localparam logic [2:0] ADDR_TIMEOUT  = 3'd2;
  localparam logic [2:0] ADDR_RESP     = 3'd3;
  localparam logic [2:0] ADDR_RESP_IDX = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;
  localparam logic [2:0] ADDR_INT_EN   = 3'd6;

  // STATUS bit positions
  localparam int ST_INHIBIT  = 0;  // command in flight (read-only, derived from FSM)
  localparam int ST_DONE     = 1;  // response received
  localparam int ST_TMO      = 2;  // response timeout or handshake loss
  localparam int ST_IDX_ERR  = 3;  // response index differs from issued index
  localparam int ST_VIOL     = 4;  // write to a command register while busy
  localparam int STATUS_W    = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  // Registers that must not move while a command is in flight
  function automatic logic is_cmd_reg(input logic [2:0] addr);
    return (addr == ADDR_ARG) || (addr == ADDR_CMD) || (addr == ADDR_TIMEOUT);
  endfunction

endpackage

// File: rtl/cmd_issue_regfile.sv
`timescale 1ns/1ps
// Register file for the command issue controller: ARG/CMD/TIMEOUT/RESP/RESP_IDX/STATUS/INT_EN, W1C, read mux, irq.
// Latency: writes visible next cycle; reads combinational; irq one cycle after STATUS.
// Backpressure: none; writes always accepted, command-register writes are dropped (and flagged) when not idle.
module cmd_issue_regfile
  import cmd_issue_pkg::*;
#(
  parameter logic [15:0] DEF_TIMEOUT = 16'h00C8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_wr,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  input  logic        idle,
  input  logic        resp_ld,
  input  logic [31:0] resp_arg,
  input  logic [5:0]  resp_idx,
  input  logic [3:1]  hw_set,
  output logic        cmd_start,
  output logic [31:0] arg,
  output logic [5:0]  cmd_idx,
  output logic [15:0] timeout,
  output logic        irq
);

  logic [31:0]         resp_q;
  logic [5:0]          resp_idx_q;
  logic [STATUS_W-1:1] status_q;
  logic [STATUS_W-1:1] status_d;
  logic [STATUS_W-1:0] status_view;
  logic [STATUS_W-1:0] int_en_q;
  logic                viol;
  logic                wr_status;

  assign viol        = reg_wr && is_cmd_reg(reg_addr) && !idle;
  assign wr_status   = reg_wr && (reg_addr == ADDR_STATUS);
  assign cmd_start   = reg_wr && (reg_addr == ADDR_CMD) && idle;
  assign status_view = {status_q, ~idle};

  // Sticky STATUS bits: W1C clear first, then hardware sets so a coincident event is never lost
  always_comb begin
    status_d = status_q;
    if (wr_status) begin
      status_d = status_d & ~reg_wdata[STATUS_W-1:1];
    end
    status_d = status_d | {viol, hw_set};
  end

  // Register state; command registers only move while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      arg        <= '0;
      cmd_idx    <= '0;
      timeout    <= DEF_TIMEOUT;
      resp_q     <= '0;
      resp_idx_q <= '0;
      status_q   <= '0;
      int_en_q   <= '0;
      irq        <= 1'b0;
    end else begin
      if (reg_wr && idle && (reg_addr == ADDR_ARG)) begin
        arg <= reg_wdata;
      end
      if (cmd_start) begin
        cmd_idx <= reg_wdata[5:0];
      end
      if (reg_wr && idle && (reg_addr == ADDR_TIMEOUT)) begin
        timeout <= reg_wdata[15:0];
      end
      if (reg_wr && (reg_addr == ADDR_INT_EN)) begin
        int_en_q <= reg_wdata[STATUS_W-1:0];
      end
      if (resp_ld) begin
        resp_q     <= resp_arg;
        resp_idx_q <= resp_idx;
      end
      status_q <= status_d;
      irq      <= |(status_view & int_en_q);
    end
  end

  // Combinational read mux; unused bits and unmapped address read zero
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_ARG:      reg_rdata = arg;
      ADDR_CMD:      reg_rdata = {26'b0, cmd_idx};
      ADDR_TIMEOUT:  reg_rdata = {16'b0, timeout};
      ADDR_RESP:     reg_rdata = resp_q;
      ADDR_RESP_IDX: reg_rdata = {26'b0, resp_idx_q};
      ADDR_STATUS:   reg_rdata = {27'b0, status_view};
      ADDR_INT_EN:   reg_rdata = {27'b0, int_en_q};
      default:       reg_rdata = '0;
    endcase
  end

endmodule

// File: rtl/cmd_issue_ctrl.sv
`timescale 1ns/1ps
// Host-side command issue controller: register interface plus IDLE/ISSUE/WAIT handshake with the CMD top level.
// Latency: CMD write at cycle N raises new_cmd at N+1; STATUS updates the edge after an event, irq one cycle later.
// Backpressure: new_cmd held until cmd_busy (bounded by HANDSHAKE_MAX); writes to command registers while busy are dropped.
module cmd_issue_ctrl
  import cmd_issue_pkg::*;
#(
  parameter logic [15:0] DEF_TIMEOUT   = 16'h00C8,
  parameter int          HANDSHAKE_MAX = 8
) (
  input  logic        CLK_host,
  input  logic        reset,
  input  logic        reg_wr,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        new_cmd,
  output logic [31:0] cmd_arg,
  output logic [5:0]  cmd_index,
  output logic [15:0] timeout_value,
  input  logic        cmd_busy,
  input  logic        cmd_complete,
  input  logic        timeout_error,
  input  logic [31:0] response_arg,
  input  logic [5:0]  response_index,
  output logic        irq
);

  localparam int HS_W = $clog2(HANDSHAKE_MAX + 1);

  state_e          state_q;
  state_e          state_d;
  logic [HS_W-1:0] hs_cnt_q;
  logic [HS_W-1:0] hs_cnt_d;
  logic            cmd_start;
  logic            resp_ld;
  logic [3:1]      hw_set;

  cmd_issue_regfile #(
    .DEF_TIMEOUT (DEF_TIMEOUT)
  ) u_regfile (
    .clk       (CLK_host),
    .reset     (reset),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .idle      (state_q == IDLE),
    .resp_ld   (resp_ld),
    .resp_arg  (response_arg),
    .resp_idx  (response_index),
    .hw_set    (hw_set),
    .cmd_start (cmd_start),
    .arg       (cmd_arg),
    .cmd_idx   (cmd_index),
    .timeout   (timeout_value),
    .irq       (irq)
  );

  // State and handshake-wait counter
  always_ff @(posedge CLK_host) begin
    if (reset) begin
      state_q  <= IDLE;
      hs_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      hs_cnt_q <= hs_cnt_d;
    end
  end

  // Next state, handshake request and STATUS/RESP update strobes
  always_comb begin
    state_d  = state_q;
    hs_cnt_d = hs_cnt_q;
    new_cmd  = 1'b0;
    resp_ld  = 1'b0;
    hw_set   = '0;
    case (state_q)
      IDLE: begin
        hs_cnt_d = '0;
        if (cmd_start) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // new_cmd drops in the same cycle the CMD top level shows busy
        if (cmd_busy) begin
          state_d = WAIT;
        end else begin
          new_cmd = 1'b1;
          if (hs_cnt_q == HS_W'(HANDSHAKE_MAX - 1)) begin
            hw_set[ST_TMO] = 1'b1;
            state_d        = IDLE;
          end else begin
            hs_cnt_d = hs_cnt_q + 1'b1;
          end
        end
      end
      WAIT: begin
        // Timeout takes priority over a coincident completion
        if (timeout_error) begin
          hw_set[ST_TMO] = 1'b1;
          state_d        = IDLE;
        end else if (cmd_complete) begin
          resp_ld         = 1'b1;
          hw_set[ST_DONE] = 1'b1;
          if (response_index != cmd_index) begin
            hw_set[ST_IDX_ERR] = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
